// File: rtl/laser_key_driver.sv
// Laser output stage for the Morse keyer: unit tick generation, input sync,
// brightness PWM and a maximum on-time cut-out with latched fault.
module laser_key_driver #(
    parameter int CLK_SPEED    = 16_000_000,
    parameter int UNIT_MS      = 100,
    parameter int PWM_BITS     = 8,
    parameter int MAX_ON_UNITS = 4
) (
    input  logic                Clock,
    input  logic                ResetN,
    input  logic                Enable,
    input  logic                ONOFF,
    input  logic                isDash,
    input  logic [PWM_BITS-1:0] Brightness,
    input  logic [PWM_BITS-1:0] DashBrightness,
    input  logic                FaultClear,
    output logic                UnitTick,
    output logic                Laser,
    output logic                Fault,
    output logic                Keying
);
    localparam int UNIT_DIV = CLK_SPEED / 1000 * UNIT_MS;
    localparam int UW       = $clog2(UNIT_DIV);
    localparam int OW       = $clog2(MAX_ON_UNITS + 1);

    localparam logic [UW-1:0]       UNIT_LAST = UW'(UNIT_DIV - 1);
    localparam logic [UW-1:0]       UNIT_ONE  = UW'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);
    localparam logic [OW-1:0]       ON_LAST   = OW'(MAX_ON_UNITS - 1);
    localparam logic [OW-1:0]       ON_MAX    = OW'(MAX_ON_UNITS);
    localparam logic [OW-1:0]       ON_ONE    = OW'(1);

    typedef enum logic [1:0] {S_OFF, S_ON, S_FAULT} state_t;

    logic [UW-1:0]       unit_cnt_q;
    logic                tick_q;
    logic                on_m_q, on_s_q, dash_m_q, dash_s_q;
    logic [PWM_BITS-1:0] pwm_cnt_q, duty_q;
    logic                pwm_on;
    state_t              state_q;
    logic [OW-1:0]       on_units_q;
    logic                laser_q, keying_q, fault_q;

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            unit_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            tick_q     <= (unit_cnt_q == UNIT_LAST);
            unit_cnt_q <= (unit_cnt_q == UNIT_LAST) ? '0 : unit_cnt_q + UNIT_ONE;
        end
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            on_m_q   <= 1'b0;
            on_s_q   <= 1'b0;
            dash_m_q <= 1'b0;
            dash_s_q <= 1'b0;
        end else begin
            on_m_q   <= ONOFF;
            on_s_q   <= on_m_q;
            dash_m_q <= isDash;
            dash_s_q <= dash_m_q;
        end
    end

    // Duty only changes at the start of a period so a period is never torn.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_ONE;
            if (pwm_cnt_q == '0)
                duty_q <= dash_s_q ? DashBrightness : Brightness;
        end
    end

    assign pwm_on = (duty_q == '1) || (pwm_cnt_q < duty_q);

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state_q    <= S_OFF;
            on_units_q <= '0;
            laser_q    <= 1'b0;
            keying_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            laser_q  <= 1'b0;
            keying_q <= 1'b0;
            fault_q  <= 1'b0;
            case (state_q)
                S_OFF: begin
                    if (Enable && on_s_q) begin
                        state_q    <= S_ON;
                        on_units_q <= '0;
                        laser_q    <= pwm_on;
                        keying_q   <= 1'b1;
                    end
                end
                S_ON: begin
                    // Over-time wins even if the key or enable drops on the same edge.
                    if (tick_q && on_units_q == ON_LAST) begin
                        state_q    <= S_FAULT;
                        on_units_q <= ON_MAX;
                        fault_q    <= 1'b1;
                    end else if (!on_s_q || !Enable) begin
                        state_q <= S_OFF;
                    end else begin
                        laser_q  <= pwm_on;
                        keying_q <= 1'b1;
                        if (tick_q)
                            on_units_q <= on_units_q + ON_ONE;
                    end
                end
                S_FAULT: begin
                    if (FaultClear && !on_s_q)
                        state_q <= S_OFF;
                    else
                        fault_q <= 1'b1;
                end
                default: state_q <= S_OFF;
            endcase
        end
    end

    assign UnitTick = tick_q;
    assign Laser    = laser_q;
    assign Fault    = fault_q;
    assign Keying   = keying_q;
endmodule

// File: tb/tb_laser_key_driver.sv
// Directed plus randomized bench for laser_key_driver, checked every cycle
// against a cycle-count based reference model.
module tb_laser_key_driver;
    localparam int UNIT_DIV = 10;
    localparam int PMAX     = 15;
    localparam int MAXU     = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, en = 1'b0, onoff = 1'b0, dash = 1'b0, fclr = 1'b0;
    logic [3:0] bri = 4'd0, dbri = 4'd0;
    logic       tick, laser, fault, keying;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    laser_key_driver #(
        .CLK_SPEED(1000), .UNIT_MS(10), .PWM_BITS(4), .MAX_ON_UNITS(MAXU)
    ) dut (
        .Clock(clk), .ResetN(rst_n), .Enable(en), .ONOFF(onoff), .isDash(dash),
        .Brightness(bri), .DashBrightness(dbri), .FaultClear(fclr),
        .UnitTick(tick), .Laser(laser), .Fault(fault), .Keying(keying)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: n = edges since reset, so unit/PWM positions are n mod N;
    // ms is 0=OFF 1=ON 2=FAULT; sync is a two-deep sample history.
    int   n, ms, units, duty, c;
    bit   mvalid = 1'b0, pwm;
    logic on_h0, on_h1, d_h0, d_h1;
    logic e_tick, e_laser, e_fault, e_key;

    task model_step();
        if (!rst_n) begin
            n = 0; ms = 0; units = 0; duty = 0;
            on_h0 = 0; on_h1 = 0; d_h0 = 0; d_h1 = 0;
            e_tick = 0; e_laser = 0; e_fault = 0; e_key = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            c   = n % (PMAX + 1);
            pwm = (duty == PMAX) || (c < duty);
            case (ms)
                0: if (en && on_h1) begin ms = 1; units = 0; end
                1: if (e_tick && units + 1 == MAXU) ms = 2;
                   else if (!on_h1 || !en) ms = 0;
                   else if (e_tick) units++;
                default: if (fclr && !on_h1) ms = 0;
            endcase
            e_laser = (ms == 1) && pwm;
            e_key   = (ms == 1);
            e_fault = (ms == 2);
            if (c == 0) duty = d_h1 ? int'(dbri) : int'(bri);
            n++;
            e_tick = (n % UNIT_DIV == 0);
            on_h1 = on_h0; on_h0 = onoff;
            d_h1  = d_h0;  d_h0  = dash;
        end
    endtask

    always @(posedge clk) model_step();

    always @(posedge clk) begin
        #2;
        if (mvalid) begin
            chk("m_tick",   tick,   e_tick);
            chk("m_laser",  laser,  e_laser);
            chk("m_fault",  fault,  e_fault);
            chk("m_keying", keying, e_key);
        end
    end

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_tick();
        int t = 0;
        do begin sample(); t++; end while (tick !== 1'b1 && t < 40);
        chk("wait_tick", tick, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt, ticks, u, gap;
        bri = 4'd4;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: tick spacing after reset release
        for (int i = 1; i <= 35; i++) begin
            sample();
            chk("t1_tick", tick, (i % 10 == 0));
        end

        // 2: dot at brightness 4
        @(negedge clk); en = 1'b1; onoff = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            sample();
            chk("t2_keyrise", keying, (i == 3));
        end
        cnt = 0;
        for (int i = 0; i < 16; i++) begin sample(); cnt += int'(laser); end
        chk("t2_duty4", cnt, 4);
        @(negedge clk); onoff = 1'b0;
        repeat (3) sample();
        chk("t2_laser_off", laser, 0);
        chk("t2_keyfall", keying, 0);

        // 3: full-brightness dash aligned to unit ticks
        @(negedge clk); dash = 1'b1; dbri = 4'd15;
        repeat (20) @(negedge clk);
        wait_tick();
        @(negedge clk); onoff = 1'b1;
        ticks = 0;
        for (int k = 1; k <= 30; k++) begin
            sample();
            if (keying) begin chk("t3_laser_on", laser, 1); ticks += int'(tick); end
        end
        @(negedge clk); onoff = 1'b0;
        repeat (3) sample();
        chk("t3_ticks", ticks, 3);
        chk("t3_nofault", fault, 0);
        chk("t3_off", keying, 0);
        @(negedge clk); dash = 1'b0;

        // 4: five-unit key -> fault on 4th tick in ON
        wait_tick();
        @(negedge clk); onoff = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            sample();
            chk("t4_fault", fault, (k >= 41));
        end
        chk("t4_laser", laser, 0);
        @(negedge clk); fclr = 1'b1;
        repeat (5) sample();
        chk("t4_clr_ignored", fault, 1);
        @(negedge clk); fclr = 1'b0; onoff = 1'b0;
        repeat (4) sample();
        chk("t4_held", fault, 1);
        @(negedge clk); fclr = 1'b1;
        sample();
        chk("t4_cleared", fault, 0);
        @(negedge clk); fclr = 1'b0;

        // 5: enable gating
        @(negedge clk); en = 1'b0; onoff = 1'b1;
        for (int i = 0; i < 15; i++) begin
            sample();
            chk("t5_dis_key", keying, 0);
            chk("t5_dis_laser", laser, 0);
        end
        @(negedge clk); en = 1'b1;
        sample();
        chk("t5_enter", keying, 1);
        repeat (3) sample();
        @(negedge clk); en = 1'b0;
        sample();
        chk("t5_drop_laser", laser, 0);
        chk("t5_drop_key", keying, 0);
        @(negedge clk); onoff = 1'b0; en = 1'b1;
        repeat (4) @(negedge clk);

        // 6: reset while in FAULT
        @(negedge clk); onoff = 1'b1;
        for (int i = 0; i < 80; i++) begin sample(); if (fault) break; end
        chk("t6_in_fault", fault, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0; onoff = 1'b0;
        sample();
        chk("t6_rst_tick", tick, 0);
        chk("t6_rst_laser", laser, 0);
        chk("t6_rst_fault", fault, 0);
        chk("t6_rst_key", keying, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            sample();
            chk("t6_tick", tick, (i == 10));
        end

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            bri  = 4'($urandom_range(0, 15));
            dbri = 4'($urandom_range(0, 15));
            wait_tick();
            @(negedge clk);
            u = $urandom_range(1, 6);
            onoff = 1'b1;
            dash  = (u >= 3);
            for (int k = 0; k < u * 10; k++) begin
                @(negedge clk);
                if ($urandom_range(0, 99) == 0) en = 1'b0;
                if ($urandom_range(0, 49) == 0) bri = 4'($urandom_range(0, 15));
                fclr = ($urandom_range(0, 9) == 0);
            end
            onoff = 1'b0;
            gap = $urandom_range(10, 30);
            for (int k = 0; k < gap; k++) begin
                @(negedge clk);
                fclr = ($urandom_range(0, 3) == 0);
                en   = 1'b1;
            end
            fclr = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
